bufid_alloc_arbiter: RTL and testbench

Owns the free packet-buffer ID pool for the host receive path. It shares that pool between several receive-side requesters, such as per-port descriptor extractors and traffic policers. At reset it seeds the pool with every buffer ID. After that it grants one free bufid per cycle by round-robin, accepts released IDs back from the transmit/free path, and publishes the live free count that the traffic policers compare against their RC/BE thresholds.

---
 rtl/bufid_alloc_arbiter_pkg.sv | 15 +
 rtl/bufid_alloc_arbiter_rr.sv | 43 ++++
 rtl/bufid_alloc_arbiter.sv | 106 ++++++++++
 tb/tb_bufid_alloc_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bufid_alloc_arbiter_pkg.sv
// Shared types and defaults for the receive-path buffer ID allocator.
// Imported by the arbiter top and its round-robin sub-module.
package bufid_alloc_arbiter_pkg;

  typedef enum logic {
    INIT_S = 1'b0,
    RUN_S  = 1'b1
  } state_t;

  localparam int DEF_BUFID_WIDTH = 9;
  localparam int DEF_BUFID_NUM   = 256;

  typedef logic [DEF_BUFID_WIDTH-1:0] bufid_t;

endpackage

// File: rtl/bufid_alloc_arbiter_rr.sv
// Round-robin arbiter: one-hot winner from a request vector.
// The search starts at the requester after the previous winner.
module rr_arbiter #(
  parameter int REQ_NUM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  input  logic               en,
  output logic [REQ_NUM-1:0] win
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;
  logic          found;
  int            idx;

  always_comb begin
    win   = '0;
    nxt   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(ptr) + i) % REQ_NUM;
      if (en && !found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
        nxt      = (idx == REQ_NUM - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/bufid_alloc_arbiter.sv
// Free buffer ID pool: seeds all IDs after reset, then grants one
// ID per cycle round-robin and takes released IDs back.
module bufid_alloc_arbiter
  import bufid_alloc_arbiter_pkg::*;
#(
  parameter int REQ_NUM     = 4,
  parameter int BUFID_WIDTH = DEF_BUFID_WIDTH,
  parameter int BUFID_NUM   = DEF_BUFID_NUM
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [REQ_NUM-1:0]     iv_alloc_req,
  output logic [REQ_NUM-1:0]     ov_alloc_grant,
  output logic [BUFID_WIDTH-1:0] ov_alloc_bufid,
  input  logic                   i_release_wr,
  input  logic [BUFID_WIDTH-1:0] iv_release_bufid,
  output logic [BUFID_WIDTH-1:0] ov_free_cnt,
  output logic                   o_init_done,
  output logic                   o_release_err
);

  localparam int PW = $clog2(BUFID_NUM);
  localparam logic [PW-1:0] LAST = PW'(BUFID_NUM - 1);
  localparam logic [BUFID_WIDTH-1:0] FULL = BUFID_WIDTH'(BUFID_NUM);

  state_t                 state;
  logic [BUFID_WIDTH-1:0] pool [BUFID_NUM];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [BUFID_WIDTH-1:0] count;
  logic [REQ_NUM-1:0]     elig;
  logic [REQ_NUM-1:0]     win;
  logic                   run;
  logic                   take;
  logic                   rel_ok;
  logic                   rel_bad;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign run     = (state == RUN_S);
  assign take    = |win;
  assign rel_ok  = run & i_release_wr & (count < FULL);
  assign rel_bad = run & i_release_wr & ~(count < FULL);
  // A requester is not re-sampled in its own grant cycle
  assign elig    = iv_alloc_req & ~ov_alloc_grant;
  assign ov_free_cnt = count;

  rr_arbiter #(
    .REQ_NUM(REQ_NUM)
  ) u_rr (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .req  (elig),
    .en   (run && (count != '0)),
    .win  (win)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (!run) begin
        pool[wr_ptr] <= BUFID_WIDTH'(wr_ptr);
      end else if (rel_ok) begin
        pool[wr_ptr] <= iv_release_bufid;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= INIT_S;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ov_alloc_grant <= '0;
      ov_alloc_bufid <= '0;
      o_init_done    <= 1'b0;
      o_release_err  <= 1'b0;
    end else begin
      ov_alloc_grant <= win;
      o_release_err  <= rel_bad;
      unique case (state)
        INIT_S: begin
          wr_ptr <= inc(wr_ptr);
          count  <= count + 1'b1;
          if (wr_ptr == LAST) begin
            o_init_done <= 1'b1;
            state       <= RUN_S;
          end
        end
        RUN_S: begin
          if (take) begin
            ov_alloc_bufid <= pool[rd_ptr];
            rd_ptr         <= inc(rd_ptr);
          end
          if (rel_ok) begin
            wr_ptr <= inc(wr_ptr);
          end
          count <= count + BUFID_WIDTH'(rel_ok) - BUFID_WIDTH'(take);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bufid_alloc_arbiter.sv
// Directed bench for bufid_alloc_arbiter: vector table plus
// hand sequences for drain, empty, full and mid-traffic reset.
module tb_bufid_alloc_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [8:0] bufid;
  logic       rel = 1'b0;
  logic [8:0] rel_id = '0;
  logic [8:0] cnt;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    logic [8:0] rel_id;
    logic [3:0] grant;
    logic [8:0] bufid;
    logic [8:0] cnt;
    logic       err;
  } vec_t;

  vec_t   tbl[10];
  logic [8:0] q[$];
  logic [8:0] e;

  always #5 clk = ~clk;

  bufid_alloc_arbiter dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .iv_alloc_req    (req),
    .ov_alloc_grant  (grant),
    .ov_alloc_bufid  (bufid),
    .i_release_wr    (rel),
    .iv_release_bufid(rel_id),
    .ov_free_cnt     (cnt),
    .o_init_done     (done),
    .o_release_err   (err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq();
    for (int k = 1; k <= 256; k++) begin
      step();
      chk("init_no_grant", grant, 0);
      chk("init_cnt", cnt, k);
      if (k == 255) chk("init_done_early", done, 0);
      if (k == 256) chk("init_done", done, 1);
    end
  endtask

  initial begin
    tbl[0] = '{4'hF, 1'b0, 9'h000, 4'h1, 9'd0, 9'd255, 1'b0};
    tbl[1] = '{4'hF, 1'b0, 9'h000, 4'h2, 9'd1, 9'd254, 1'b0};
    tbl[2] = '{4'hF, 1'b0, 9'h000, 4'h4, 9'd2, 9'd253, 1'b0};
    tbl[3] = '{4'hF, 1'b0, 9'h000, 4'h8, 9'd3, 9'd252, 1'b0};
    tbl[4] = '{4'hF, 1'b0, 9'h000, 4'h1, 9'd4, 9'd251, 1'b0};
    tbl[5] = '{4'h0, 1'b1, 9'h1F3, 4'h0, 9'd0, 9'd252, 1'b0};
    tbl[6] = '{4'h2, 1'b0, 9'h000, 4'h2, 9'd5, 9'd251, 1'b0};
    tbl[7] = '{4'h9, 1'b0, 9'h000, 4'h8, 9'd6, 9'd250, 1'b0};
    tbl[8] = '{4'h1, 1'b1, 9'h055, 4'h1, 9'd7, 9'd250, 1'b0};
    tbl[9] = '{4'h0, 1'b0, 9'h000, 4'h0, 9'd0, 9'd250, 1'b0};

    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_bufid", bufid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    init_seq();

    for (int i = 0; i < 10; i++) begin
      req    = tbl[i].req;
      rel    = tbl[i].rel;
      rel_id = tbl[i].rel_id;
      step();
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
      if (tbl[i].grant != 0)
        chk($sformatf("vec%0d_bufid", i), bufid, tbl[i].bufid);
    end
    rel = 1'b0;

    for (int i = 8; i < 256; i++) q.push_back(9'(i));
    q.push_back(9'h1F3);
    q.push_back(9'h055);

    req = 4'hF;
    for (int i = 0; i < 240; i++) begin
      e = q.pop_front();
      step();
      chk("drain_onehot", 32'($onehot(grant)), 1);
      chk("drain_bufid", bufid, e);
      chk("drain_cnt", cnt, q.size());
    end

    rel    = 1'b1;
    rel_id = 9'h0AB;
    e = q.pop_front();
    q.push_back(9'h0AB);
    step();
    rel = 1'b0;
    chk("same_onehot", 32'($onehot(grant)), 1);
    chk("same_bufid", bufid, e);
    chk("same_cnt", cnt, 10);

    for (int i = 0; i < 10; i++) begin
      e = q.pop_front();
      step();
      chk("tail_onehot", 32'($onehot(grant)), 1);
      chk("tail_bufid", bufid, e);
      chk("tail_cnt", cnt, q.size());
    end
    step();
    chk("empty_no_grant", grant, 0);
    chk("empty_cnt", cnt, 0);

    req    = 4'b0100;
    rel    = 1'b1;
    rel_id = 9'h02A;
    step();
    rel = 1'b0;
    chk("bnd_no_grant", grant, 0);
    chk("bnd_cnt1", cnt, 1);
    step();
    req = 4'h0;
    chk("bnd_grant", grant, 4'b0100);
    chk("bnd_bufid", bufid, 9'h02A);
    chk("bnd_cnt0", cnt, 0);

    req    = 4'hF;
    rel    = 1'b1;
    rel_id = 9'h033;
    step();
    rel = 1'b0;
    step();
    chk("pre_rst_grant", 32'($onehot(grant)), 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_bufid", bufid, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    rst_n = 1'b1;
    init_seq();

    req    = 4'h0;
    rel    = 1'b1;
    rel_id = 9'h011;
    step();
    rel = 1'b0;
    chk("full_err", err, 1);
    chk("full_cnt", cnt, 256);
    chk("full_no_grant", grant, 0);
    step();
    chk("full_err_pulse", err, 0);
    chk("full_cnt_hold", cnt, 256);

    req = 4'hF;
    step();
    chk("reinit_grant", grant, 4'b0001);
    chk("reinit_bufid", bufid, 0);
    chk("reinit_cnt", cnt, 255);
    step();
    req = 4'h0;
    chk("reinit_grant2", grant, 4'b0010);
    chk("reinit_bufid2", bufid, 1);
    chk("reinit_cnt2", cnt, 254);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
